adc_acq_axil_regfile: RTL and testbench
=======================================

// Module: adc_acq_axil_regfile
// PURPOSE
//  Parametrised AXI4-Lite slave register file; successor to the fixed 4x32-bit ADC acquisition control slave.
//  Generalises word width and register count, and splits registers into RW control and RO status.
//  Adds byte strobes, SLVERR decode, per-register write pulses and an optional W1C interrupt bank.
//  Sits between the PS GP master and the ADC-to-DDR acquisition datapath.
// PARAMETERS
//  DATA_W    32  AXI data / register width; 32 or 64
//  ADDR_W    8   AXI byte-address width; must cover (NUM_RW+NUM_RO+2)*(DATA_W/8) bytes
//  NUM_RW    4   RW control registers, word index 0..NUM_RW-1
//  NUM_RO    2   RO status registers, word index NUM_RW..NUM_RW+NUM_RO-1
//  IRQ_W     4   interrupt source count, <= DATA_W
//  RW_RST    '0  reset value of every RW register
// PORTS
//  ACLK            in   1              clock
//  ARESETN         in   1              async active-low reset
//  S_AXI_AWADDR    in   ADDR_W         write address
//  S_AXI_AWPROT    in   3              ignored
//  S_AXI_AWVALID   in   1              | S_AXI_AWREADY  out  1
//  S_AXI_WDATA     in   DATA_W         write data
//  S_AXI_WSTRB     in   DATA_W/8       byte enables
//  S_AXI_WVALID    in   1              | S_AXI_WREADY   out  1
//  S_AXI_BRESP     out  2              OKAY=00, SLVERR=10
//  S_AXI_BVALID    out  1              | S_AXI_BREADY   in   1
//  S_AXI_ARADDR    in   ADDR_W         read address
//  S_AXI_ARPROT    in   3              ignored
//  S_AXI_ARVALID   in   1              | S_AXI_ARREADY  out  1
//  S_AXI_RDATA     out  DATA_W         read data
//  S_AXI_RRESP     out  2              OKAY / SLVERR
//  S_AXI_RVALID    out  1              | S_AXI_RREADY   in   1
//  rw_regs_o       out  NUM_RW*DATA_W  RW register contents, reg k at [k*DATA_W +: DATA_W]
//  wr_pulse_o      out  NUM_RW         1-cycle strobe, cycle the RW reg is written
//  ro_regs_i       in   NUM_RO*DATA_W  status inputs, sampled at read
//  irq_set_i       in   IRQ_W          level/pulse sets sticky status bit
//  irq_o           out  1              |(irq_status & irq_enable)
// BEHAVIOUR
//  Reset: all READY/VALID 0, BRESP/RRESP 00, RDATA 0, RW regs = RW_RST, pulses 0, IRQ regs 0, irq_o 0.
//  Word index = ADDR[ADDR_W-1:log2(DATA_W/8)]; low address bits ignored.
//  AW and W each captured in a 1-entry hold; AWREADY/WREADY = hold empty; independent arrival order allowed.
//  Write commits the cycle after both holds full and B not pending. Commit cycle: reg update, wr_pulse_o, BVALID=1.
//  BVALID/BRESP held until BREADY; holds free on commit; next write may commit the cycle after B handshake.
//  Bytes with WSTRB=0 unchanged. Write to RO index or unmapped index: no state change, BRESP=SLVERR.
//  Read: ARREADY = !RVALID. RVALID+RDATA+RRESP registered 1 cycle after AR handshake, stable until RREADY.
//  Unmapped read: RDATA=0, RRESP=SLVERR. RO read returns ro_regs_i at AR-handshake cycle.
//  Read and write channels are independent; a same-cycle read of a reg being committed returns the old value.
//  ARESETN low mid-transaction: outstanding AW/W/B/R dropped, no response issued, all state to reset values.
// CONFIGURATION
//  ADC_ACQ_REGFILE_IRQ_EN defined:
//    index NUM_RW+NUM_RO = IRQ_STATUS (W1C, bits IRQ_W-1:0); index +1 = IRQ_ENABLE (RW).
//    Status bit set by irq_set_i; W1C clears. Same-cycle set and clear: set wins.
//    irq_o registered, 1-cycle lag after status/enable change.
//  Not defined: both indices unmapped (SLVERR), irq_o tied 0, irq_set_i unused.
// STRUCTURE
//  Package adc_acq_regfile_pkg: resp_t enum (OKAY, SLVERR), function word_idx(addr), localparam IRQ_STATUS_OFS/IRQ_ENABLE_OFS.
//  Sub-module axil_hold_slot: 1-entry valid/ready holding register, instanced for AW and W.
// TESTING
//  Write 0x11..0x44 to idx 0..3, read back -> RDATA match, RRESP 00, wr_pulse_o[k] one cycle each.
//  W before AW by 3 cycles, data 0xA5A5A5A5 to idx 1 -> single commit, BVALID 1 cycle after AW accepted.
//  WSTRB=0b0010, data 0xFFFFFFFF to reg holding 0x12345678 -> reg reads 0x1234FF78.
//  Write idx 4 (RO) and idx 63 -> BRESP 10, regs unchanged; read idx 63 -> RDATA 0, RRESP 10.
//  IRQ_EN: irq_set_i[2] pulse, enable=0x4 -> irq_o 1; W1C 0x4 with set_i[2] same cycle -> bit stays 1.
//  BREADY/RREADY held low 10 cycles -> B/R stable, AWREADY/ARREADY stay 0; ARESETN low mid-burst -> all VALIDs 0.

Source files
------------

// File: rtl/adc_acq_regfile_pkg.sv
// Shared types and helpers for the ADC acquisition AXI4-Lite register file.
package adc_acq_regfile_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Interrupt bank word offsets, relative to the first index after the RO block
    localparam int IRQ_STATUS_OFS = 0;
    localparam int IRQ_ENABLE_OFS = 1;

    // Word index of a byte address; lsb = log2 of the bytes per word
    function automatic int unsigned word_idx(input logic [63:0] addr, input int unsigned lsb);
        return 32'(addr >> lsb);
    endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready holding register; accepts a beat while empty and
// keeps it until the consumer pops it.
module axil_hold_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         pop
);

    logic         alive_q;
    logic         full_q;
    logic [W-1:0] data_q;

    // alive_q keeps READY low while reset is asserted and for the first cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            alive_q <= 1'b1;
            if (pop) begin
                full_q <= 1'b0;
            end else if (in_valid && in_ready) begin
                full_q <= 1'b1;
                data_q <= in_data;
            end
        end
    end

    assign in_ready  = alive_q && !full_q;
    assign out_data  = data_q;
    assign out_valid = full_q;

endmodule

// File: rtl/adc_acq_axil_regfile.sv
// AXI4-Lite slave register file: RW control words, RO status words and, when
// ADC_ACQ_REGFILE_IRQ_EN is defined, a W1C interrupt status/enable pair.
module adc_acq_axil_regfile
    import adc_acq_regfile_pkg::*;
#(
    parameter int              DATA_W = 32,
    parameter int              ADDR_W = 8,
    parameter int              NUM_RW = 4,
    parameter int              NUM_RO = 2,
    parameter int              IRQ_W  = 4,
    parameter logic [DATA_W-1:0] RW_RST = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [DATA_W-1:0]        S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [DATA_W-1:0]        S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_RW*DATA_W-1:0] rw_regs_o,
    output logic [NUM_RW-1:0]        wr_pulse_o,
    input  logic [NUM_RO*DATA_W-1:0] ro_regs_i,
    input  logic [IRQ_W-1:0]         irq_set_i,
    output logic                     irq_o
);

    localparam int          STRB_W      = DATA_W / 8;
    localparam int unsigned LSB         = $clog2(STRB_W);
    localparam int unsigned RW_END      = NUM_RW;
    localparam int unsigned RO_END      = NUM_RW + NUM_RO;
    localparam int unsigned IRQ_STS_IDX = RO_END + IRQ_STATUS_OFS;
    localparam int unsigned IRQ_EN_IDX  = RO_END + IRQ_ENABLE_OFS;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] new_v,
                                                      input logic [DATA_W-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [ADDR_W-1:0]        aw_addr;
    logic                     aw_full;
    logic [DATA_W+STRB_W-1:0] w_bus;
    logic                     w_full;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic                     commit;

    logic                     bvalid_q;
    resp_t                    bresp_q;
    logic                     ar_alive_q;
    logic                     rvalid_q;
    resp_t                    rresp_q;
    logic [DATA_W-1:0]        rdata_q;

    logic [DATA_W-1:0]        rw_q [NUM_RW];
    logic [NUM_RW-1:0]        wr_pulse_q;

    int unsigned              wr_idx;
    int unsigned              rd_idx;
    logic                     wr_is_rw;
    logic                     wr_ok;
    logic [DATA_W-1:0]        wr_mask;
    logic [DATA_W-1:0]        rd_data;
    resp_t                    rd_resp;

    axil_hold_slot #(.W(ADDR_W)) u_aw_slot (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .in_data  (S_AXI_AWADDR),
        .in_valid (S_AXI_AWVALID),
        .in_ready (S_AXI_AWREADY),
        .out_data (aw_addr),
        .out_valid(aw_full),
        .pop      (commit)
    );

    axil_hold_slot #(.W(DATA_W + STRB_W)) u_w_slot (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .in_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .in_valid (S_AXI_WVALID),
        .in_ready (S_AXI_WREADY),
        .out_data (w_bus),
        .out_valid(w_full),
        .pop      (commit)
    );

    assign w_data = w_bus[DATA_W-1:0];
    assign w_strb = w_bus[DATA_W +: STRB_W];
    // A pending B response blocks the next commit, so the holds stay full meanwhile
    assign commit = aw_full && w_full && !bvalid_q;
    assign wr_idx = word_idx(64'(aw_addr), LSB);
    assign rd_idx = word_idx(64'(S_AXI_ARADDR), LSB);

    always_comb begin
        wr_mask  = '0;
        wr_is_rw = (wr_idx < RW_END);
        wr_ok    = wr_is_rw;
`ifdef ADC_ACQ_REGFILE_IRQ_EN
        if (wr_idx == IRQ_STS_IDX || wr_idx == IRQ_EN_IDX) wr_ok = 1'b1;
`endif
        for (int b = 0; b < STRB_W; b++) begin
            wr_mask[b*8 +: 8] = {8{w_strb[b]}};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_RW; k++) rw_q[k] <= RW_RST;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (commit && wr_is_rw && wr_idx == k) begin
                    rw_q[k]       <= merge_bytes(rw_q[k], w_data, wr_mask);
                    wr_pulse_q[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

`ifdef ADC_ACQ_REGFILE_IRQ_EN
    logic [IRQ_W-1:0]  irq_sts_q;
    logic [DATA_W-1:0] irq_en_q;
    logic              irq_q;
    logic [IRQ_W-1:0]  irq_clr;

    always_comb begin
        irq_clr = '0;
        for (int b = 0; b < IRQ_W; b++) begin
            irq_clr[b] = commit && (wr_idx == IRQ_STS_IDX) && w_data[b] && w_strb[b/8];
        end
    end

    // Set is OR-ed in after the clear so a simultaneous set survives the W1C
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_sts_q <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            irq_sts_q <= (irq_sts_q & ~irq_clr) | irq_set_i;
            if (commit && wr_idx == IRQ_EN_IDX) irq_en_q <= merge_bytes(irq_en_q, w_data, wr_mask);
            irq_q <= |(irq_sts_q & irq_en_q[IRQ_W-1:0]);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_idx == k) begin
                rd_data = rw_q[k];
                rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (rd_idx == RW_END + k) begin
                rd_data = ro_regs_i[k*DATA_W +: DATA_W];
                rd_resp = RESP_OKAY;
            end
        end
`ifdef ADC_ACQ_REGFILE_IRQ_EN
        if (rd_idx == IRQ_STS_IDX) begin
            rd_data = DATA_W'(irq_sts_q);
            rd_resp = RESP_OKAY;
        end
        if (rd_idx == IRQ_EN_IDX) begin
            rd_data = irq_en_q;
            rd_resp = RESP_OKAY;
        end
`endif
    end

    // Read response stage: captured on the AR handshake, held until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_alive_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            ar_alive_q <= 1'b1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                rdata_q  <= rd_data;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = ar_alive_q && !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign wr_pulse_o    = wr_pulse_q;

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw_out
        assign rw_regs_o[k*DATA_W +: DATA_W] = rw_q[k];
    end

`ifdef ADC_ACQ_REGFILE_IRQ_EN
    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT};
`else
    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, irq_set_i};
`endif

endmodule

// File: tb/tb_adc_acq_axil_regfile.sv
// Self-checking bench for adc_acq_axil_regfile (default parameters); directed
// steps plus a randomized phase against a word/byte-level reference model.
module tb_adc_acq_axil_regfile;

`ifdef ADC_ACQ_REGFILE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [7:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] rw_regs;
    logic [3:0]   wr_pulse;
    logic [63:0]  ro_regs = '0;
    logic [3:0]   irq_set = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_rw [4];
    logic [31:0] model_en;
    logic [31:0] model_sts;
    int          exp_pulse [4];
    int          pulse_cnt [4];

    adc_acq_axil_regfile dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .rw_regs_o(rw_regs), .wr_pulse_o(wr_pulse), .ro_regs_i(ro_regs),
        .irq_set_i(irq_set), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
    always @(negedge clk) begin
        if (rst_n) for (int k = 0; k < 4; k++) pulse_cnt[k] = pulse_cnt[k] + int'(wr_pulse[k]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mapped_w(input int idx);
        return (idx < 4) || (IRQ_EN && (idx == 6 || idx == 7));
    endfunction

    function automatic bit mapped_r(input int idx);
        return (idx < 6) || (IRQ_EN && (idx == 6 || idx == 7));
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit aw_done, w_done, got, aw_hs, w_hs;
        aw_done = 0; w_done = 0; got = 0;
        awaddr  = 8'(idx * 4 + int'($urandom_range(0, 3)));
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_accept_timeout", 0, 1);
        resp   = 2'bxx;
        bready = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            if (bvalid) begin resp = bresp; got = 1; end
            tick();
        end
        bready = 1'b0;
        if (!got) chk("bvalid_timeout", 0, 1);
    endtask

    task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
        bit done, got, hs;
        done = 0; got = 0;
        araddr  = 8'(idx * 4 + int'($urandom_range(0, 3)));
        arvalid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            hs = arready;
            tick();
            if (hs) done = 1;
        end
        arvalid = 1'b0;
        if (!done) chk("ar_accept_timeout", 0, 1);
        data   = 'x;
        resp   = 2'bxx;
        rready = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            if (rvalid) begin data = rdata; resp = rresp; got = 1; end
            tick();
        end
        rready = 1'b0;
        if (!got) chk("rvalid_timeout", 0, 1);
    endtask

    task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp;
        axi_write(idx, data, strb, resp);
        chk($sformatf("bresp_idx%0d", idx), 64'(resp), mapped_w(idx) ? 64'h0 : 64'h2);
        if (idx < 4) begin
            model_rw[idx] = byte_merge(model_rw[idx], data, strb);
            exp_pulse[idx]++;
        end else if (IRQ_EN && idx == 7) begin
            model_en = byte_merge(model_en, data, strb);
        end
    endtask

    task automatic do_read(input int idx);
        logic [31:0] d, exp_d;
        logic [1:0]  r;
        axi_read(idx, d, r);
        exp_d = 32'h0;
        if (idx < 4)                        exp_d = model_rw[idx];
        else if (idx < 6)                   exp_d = ro_regs[(idx-4)*32 +: 32];
        else if (IRQ_EN && idx == 6)        exp_d = model_sts;
        else if (IRQ_EN && idx == 7)        exp_d = model_en;
        chk($sformatf("rdata_idx%0d", idx), 64'(d), 64'(exp_d));
        chk($sformatf("rresp_idx%0d", idx), 64'(r), mapped_r(idx) ? 64'h0 : 64'h2);
    endtask

    task automatic chk_rw_outputs(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_rw%0d", tag, k), 64'(rw_regs[k*32 +: 32]), 64'(model_rw[k]));
    endtask

    initial begin
        logic [31:0] d_first, d_second;
        for (int k = 0; k < 4; k++) begin model_rw[k] = 32'h0; exp_pulse[k] = 0; end
        model_en  = 32'h0;
        model_sts = 32'h0;

        // reset state
        tick(); tick();
        chk("rst_awready", 64'(awready), 0);
        chk("rst_wready",  64'(wready), 0);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_bvalid",  64'(bvalid), 0);
        chk("rst_rvalid",  64'(rvalid), 0);
        chk("rst_bresp",   64'(bresp), 0);
        chk("rst_rresp",   64'(rresp), 0);
        chk("rst_rdata",   64'(rdata), 0);
        chk("rst_pulse",   64'(wr_pulse), 0);
        chk("rst_irq",     64'(irq), 0);
        chk_rw_outputs("rst");
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_wready",  64'(wready), 1);
        chk("post_rst_arready", 64'(arready), 1);

        // basic write/readback of every RW register
        for (int k = 0; k < 4; k++) do_write(k, 32'h11 * (k + 1), 4'hF);
        for (int k = 0; k < 4; k++) do_read(k);
        chk("rw0_const", 64'(rw_regs[31:0]), 64'h11);
        chk("rw3_const", 64'(rw_regs[127:96]), 64'h44);
        chk_rw_outputs("basic");

        // W arrives 3 cycles before AW
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("w_first_no_bvalid", 64'(bvalid), 0);
            tick();
        end
        awaddr = 8'h04; awvalid = 1'b1;
        chk("w_first_awready", 64'(awready), 1);
        tick();
        awvalid = 1'b0;
        chk("w_first_bvalid_early", 64'(bvalid), 0);
        tick();
        chk("w_first_bvalid", 64'(bvalid), 1);
        chk("w_first_bresp", 64'(bresp), 0);
        chk("w_first_pulse", 64'(wr_pulse), 64'b0010);
        model_rw[1] = 32'hA5A5A5A5;
        exp_pulse[1]++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("w_first_bvalid_clr", 64'(bvalid), 0);
        chk("w_first_pulse_clr", 64'(wr_pulse), 0);
        chk("w_first_rw1", 64'(rw_regs[63:32]), 64'hA5A5A5A5);

        // byte strobes
        do_write(2, 32'h12345678, 4'hF);
        do_write(2, 32'hFFFFFFFF, 4'b0010);
        chk("strb_rw2", 64'(rw_regs[95:64]), 64'h1234FF78);
        do_read(2);

        // RO and unmapped writes, unmapped and RO reads
        ro_regs = {$urandom, $urandom};
        do_write(4, 32'hDEADBEEF, 4'hF);
        do_write(63, 32'hCAFEF00D, 4'hF);
        chk_rw_outputs("slverr");
        do_read(63);
        do_read(4);
        do_read(5);

        // interrupt bank
`ifdef ADC_ACQ_REGFILE_IRQ_EN
        do_write(7, 32'h4, 4'hF);
        do_read(7);
        chk("irq_idle", 64'(irq), 0);
        irq_set = 4'b0100;
        tick();
        irq_set = 4'b0000;
        tick();
        chk("irq_set", 64'(irq), 1);
        model_sts = 32'h4;
        do_read(6);
        irq_set = 4'b0100;
        do_write(6, 32'h4, 4'hF);
        irq_set = 4'b0000;
        do_read(6);
        chk("irq_set_wins", 64'(irq), 1);
        do_write(6, 32'h4, 4'hF);
        model_sts = 32'h0;
        tick(); tick();
        chk("irq_cleared", 64'(irq), 0);
        do_read(6);
`else
        irq_set = 4'hF;
        tick(); tick(); tick();
        chk("irq_tied_low", 64'(irq), 0);
        irq_set = 4'h0;
        do_write(6, 32'hF, 4'hF);
        do_write(7, 32'hF, 4'hF);
        do_read(6);
        do_read(7);
`endif

        // back-pressure on B and R
        d_first  = $urandom;
        d_second = $urandom;
        awaddr = 8'h0C; wdata = d_first; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("stall_bvalid_first", 64'(bvalid), 1);
        model_rw[3] = d_first; exp_pulse[3]++;
        awaddr = 8'h00; wdata = d_second; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h0C; arvalid = 1'b1;
        chk("stall_awready_free", 64'(awready), 1);
        chk("stall_arready_free", 64'(arready), 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("stall_bvalid", 64'(bvalid), 1);
            chk("stall_bresp", 64'(bresp), 0);
            chk("stall_awready", 64'(awready), 0);
            chk("stall_wready", 64'(wready), 0);
            chk("stall_rvalid", 64'(rvalid), 1);
            chk("stall_rdata", 64'(rdata), 64'(d_first));
            chk("stall_arready", 64'(arready), 0);
            chk("stall_rw0_held", 64'(rw_regs[31:0]), 64'(model_rw[0]));
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("stall_bvalid_gap", 64'(bvalid), 0);
        chk("stall_rvalid_clr", 64'(rvalid), 0);
        tick();
        chk("stall_second_bvalid", 64'(bvalid), 1);
        chk("stall_second_pulse", 64'(wr_pulse), 64'b0001);
        model_rw[0] = d_second; exp_pulse[0]++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk_rw_outputs("stall");

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            int r, idx;
            r = int'($urandom_range(0, 9));
            if (r < 6)      idx = r;
            else if (r < 8) idx = IRQ_EN ? 63 : r;
            else            idx = int'($urandom_range(8, 63));
            if ($urandom_range(0, 1) == 1) begin
                do_write(idx, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                ro_regs = {$urandom, $urandom};
                do_read(idx);
            end
        end
        chk_rw_outputs("rand");
        for (int k = 0; k < 4; k++) chk($sformatf("pulse_count%0d", k), 64'(pulse_cnt[k]), 64'(exp_pulse[k]));

        // reset in the middle of outstanding AW/W/AR
        awaddr = 8'h00; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("midrst_rvalid_before", 64'(rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", 64'(bvalid), 0);
        chk("midrst_rvalid", 64'(rvalid), 0);
        chk("midrst_awready", 64'(awready), 0);
        chk("midrst_arready", 64'(arready), 0);
        chk("midrst_pulse", 64'(wr_pulse), 0);
        for (int k = 0; k < 4; k++) model_rw[k] = 32'h0;
        model_en = 32'h0;
        model_sts = 32'h0;
        chk_rw_outputs("midrst");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("post_midrst_no_bvalid", 64'(bvalid), 0);
            chk("post_midrst_no_rvalid", 64'(rvalid), 0);
            tick();
        end
        do_read(0);
        do_read(1);
        for (int k = 0; k < 4; k++) chk($sformatf("final_pulse_count%0d", k), 64'(pulse_cnt[k]), 64'(exp_pulse[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
